// File: rtl/mn_stream_load.sv
// Streaming matrix loader: accepts row-major elements over valid/ready and
// issues one registered storage write per element, optionally transposed.
module mn_stream_load #(
  parameter int MAX_DIM = 128,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    m_dim,
  input  logic [7:0]    n_dim,
  input  logic          transpose,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          write,
  output logic [7:0]    m_addr,
  output logic [7:0]    n_addr,
  output logic [DW-1:0] data_in,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [8:0] MAX_DIM_W = 9'(MAX_DIM);

  state_t        state_q, state_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    c_q, c_d;
  logic [7:0]    m_dim_q, m_dim_d;
  logic [7:0]    n_dim_q, n_dim_d;
  logic          tr_q, tr_d;
  logic          write_q, write_d;
  logic [7:0]    m_addr_q, m_addr_d;
  logic [7:0]    n_addr_q, n_addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          start_legal;
  logic          last_col;
  logic          last_row;

  function automatic logic dim_legal(input logic [7:0] d);
    return (d != 8'd0) && ({1'b0, d} <= MAX_DIM_W);
  endfunction

  // Wrap points come from the captured dims so live dim inputs cannot disturb a load.
  assign accept      = (state_q == LOAD) && in_valid && !abort;
  assign start_legal = dim_legal(m_dim) && dim_legal(n_dim);
  assign last_col    = (c_q == n_dim_q - 8'd1);
  assign last_row    = (r_q == m_dim_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    m_dim_d  = m_dim_q;
    n_dim_d  = n_dim_q;
    tr_d     = tr_q;
    write_d  = 1'b0;
    m_addr_d = m_addr_q;
    n_addr_d = n_addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (start_legal) begin
            state_d = LOAD;
            m_dim_d = m_dim;
            n_dim_d = n_dim;
            tr_d    = transpose;
            r_d     = 8'd0;
            c_d     = 8'd0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          write_d  = 1'b1;
          data_d   = in_data;
          m_addr_d = tr_q ? c_q : r_q;
          n_addr_d = tr_q ? r_q : c_q;
          if (last_col) begin
            c_d = 8'd0;
            if (last_row) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              r_d = r_q + 8'd1;
            end
          end else begin
            c_d = c_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a final beat and its done pulse.
    if (abort) begin
      state_d = IDLE;
      write_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d == LOAD) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      r_q      <= 8'd0;
      c_q      <= 8'd0;
      m_dim_q  <= 8'd0;
      n_dim_q  <= 8'd0;
      tr_q     <= 1'b0;
      write_q  <= 1'b0;
      m_addr_q <= 8'd0;
      n_addr_q <= 8'd0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      m_dim_q  <= m_dim_d;
      n_dim_q  <= n_dim_d;
      tr_q     <= tr_d;
      write_q  <= write_d;
      m_addr_q <= m_addr_d;
      n_addr_q <= n_addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in_ready = (state_q == LOAD);
  assign write    = write_q;
  assign m_addr   = m_addr_q;
  assign n_addr   = n_addr_q;
  assign data_in  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mn_stream_load.sv
// Directed bench for mn_stream_load: row-major, transpose, stalls, illegal
// dims, abort, mid-load reset and a full 128x128 load.
module tb_mn_stream_load;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  m_dim;
  logic [7:0]  n_dim;
  logic        transpose;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        write;
  logic [7:0]  m_addr;
  logic [7:0]  n_addr;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation log filled by drive_load
  logic [7:0]  wr_m   [16384];
  logic [7:0]  wr_n   [16384];
  logic [31:0] wr_d   [16384];
  int          wr_cyc [16384];
  int          n_wr;
  int          n_done;
  int          done_cyc;
  logic        done_wr;
  logic        done_rdy;
  logic        busy0;
  logic        ready0;
  logic        err0;
  logic        abort_wr;
  logic        abort_busy;

  mn_stream_load #(.MAX_DIM(128), .DW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .m_dim(m_dim), .n_dim(n_dim), .transpose(transpose),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write(write), .m_addr(m_addr), .n_addr(n_addr), .data_in(data_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a load and streams elements 1,2,3...; records what the DUT writes.
  // Cycle index cyc counts edges after the start-accepting edge.
  task automatic drive_load(input logic [7:0] m, input logic [7:0] n, input logic tr,
                            input int vmode, input int abort_beat, input int max_cyc);
    int   beats;
    logic v;
    logic ab;
    n_wr = 0; n_done = 0; done_cyc = -1; done_wr = 0; done_rdy = 1;
    abort_wr = 1; abort_busy = 1; beats = 0;
    m_dim = m; n_dim = n; transpose = tr; start = 1; in_valid = 0;
    tick;
    start = 0; m_dim = 8'hFF; n_dim = 8'hFF; transpose = ~tr;
    busy0 = busy; ready0 = in_ready; err0 = err;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      v  = (vmode == 0) ? 1'b1 : ((cyc % 2) == 1);
      ab = (abort_beat >= 0) && v && (beats == abort_beat);
      in_valid = v;
      in_data  = v ? 32'(beats + 1) : (32'hDEAD_0000 + 32'(cyc));
      abort    = ab;
      if (in_ready && v && !ab) beats++;
      tick;
      if (write) begin
        if (n_wr < 16384) begin
          wr_m[n_wr] = m_addr; wr_n[n_wr] = n_addr; wr_d[n_wr] = data_in; wr_cyc[n_wr] = cyc;
        end
        n_wr++;
      end
      if (done) begin
        n_done++; done_cyc = cyc; done_wr = write; done_rdy = in_ready;
      end
      if (ab) begin
        abort_wr = write; abort_busy = busy;
      end
      abort = 0;
      if (!busy) break;
    end
    in_valid = 0; transpose = 0; m_dim = 0; n_dim = 0; in_data = 0;
  endtask

  task automatic test_reset;
    reset = 0; start = 0; abort = 0; m_dim = 0; n_dim = 0;
    transpose = 0; in_valid = 0; in_data = 0;
    #3;
    n_checks++;
    if ({in_ready, write, busy, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, write, busy, done, err});
    end
    n_checks++;
    if ({m_addr, n_addr, data_in} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {m_addr, n_addr, data_in});
    end
    tick; tick;
    #2 reset = 1;
    tick;
    n_checks++;
    if ({in_ready, busy, write} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {in_ready, busy, write});
    end
  endtask

  task automatic test_row_major;
    drive_load(8'd2, 8'd3, 1'b0, 0, -1, 40);
    n_checks++;
    if ({busy0, ready0} !== 2'b11) begin
      n_fail++; $display("FAIL rm_start_flags: got %b expected 11", {busy0, ready0});
    end
    n_checks++;
    if (n_wr !== 6) begin
      n_fail++; $display("FAIL rm_write_count: got %0d expected 6", n_wr);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({wr_m[i], wr_n[i], wr_d[i]} !== {8'(i / 3), 8'(i % 3), 32'(i + 1)} || wr_cyc[i] !== i + 1) begin
        n_fail++;
        $display("FAIL rm_write[%0d]: got (%0d,%0d) d=%0d cyc=%0d expected (%0d,%0d) d=%0d cyc=%0d",
                 i, wr_m[i], wr_n[i], wr_d[i], wr_cyc[i], i / 3, i % 3, i + 1, i + 1);
      end
    end
    n_checks++;
    if (n_done !== 1 || done_cyc !== 6 || done_wr !== 1'b1 || done_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_done: got count=%0d cyc=%0d wr=%b rdy=%b expected count=1 cyc=6 wr=1 rdy=0",
               n_done, done_cyc, done_wr, done_rdy);
    end
  endtask

  task automatic test_back_to_back_transpose;
    drive_load(8'd2, 8'd3, 1'b1, 0, -1, 40);
    n_checks++;
    if (n_wr !== 6 || n_done !== 1 || done_cyc !== 6) begin
      n_fail++; $display("FAIL tr_counts: got wr=%0d done=%0d cyc=%0d expected wr=6 done=1 cyc=6",
                         n_wr, n_done, done_cyc);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({wr_m[i], wr_n[i], wr_d[i]} !== {8'(i % 3), 8'(i / 3), 32'(i + 1)}) begin
        n_fail++;
        $display("FAIL tr_write[%0d]: got (%0d,%0d) d=%0d expected (%0d,%0d) d=%0d",
                 i, wr_m[i], wr_n[i], wr_d[i], i % 3, i / 3, i + 1);
      end
    end
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    drive_load(8'd3, 8'd3, 1'b0, 1, -1, 60);
    n_checks++;
    if (n_wr !== 9) begin
      n_fail++; $display("FAIL stall_write_count: got %0d expected 9", n_wr);
    end
    for (int i = 0; i < 9; i++) begin
      if ({wr_m[i], wr_n[i], wr_d[i]} !== {8'(i / 3), 8'(i % 3), 32'(i + 1)} || wr_cyc[i] !== 2 * i + 1)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL stall_sequence: got %0d bad writes expected 0", bad);
    end
    n_checks++;
    if (n_done !== 1 || done_cyc !== 17) begin
      n_fail++; $display("FAIL stall_done: got count=%0d cyc=%0d expected count=1 cyc=17", n_done, done_cyc);
    end
  endtask

  task automatic test_illegal_dims;
    m_dim = 8'd0; n_dim = 8'd3; start = 1;
    tick;
    start = 0;
    n_checks++;
    if ({err, busy, in_ready, write} !== 4'b1000) begin
      n_fail++; $display("FAIL err_m_zero: got %b expected 1000", {err, busy, in_ready, write});
    end
    m_dim = 8'd2; n_dim = 8'd129; start = 1;
    tick;
    start = 0;
    tick;
    n_checks++;
    if ({err, busy, in_ready, write} !== 4'b1000) begin
      n_fail++; $display("FAIL err_n_129: got %b expected 1000", {err, busy, in_ready, write});
    end
    drive_load(8'd1, 8'd1, 1'b0, 0, -1, 10);
    n_checks++;
    if (err0 !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b%b expected 00", err0, err);
    end
    n_checks++;
    if (n_wr !== 1 || wr_m[0] !== 8'd0 || wr_n[0] !== 8'd0 || wr_d[0] !== 32'd1) begin
      n_fail++; $display("FAIL one_by_one_write: got n=%0d (%0d,%0d) d=%0d expected n=1 (0,0) d=1",
                         n_wr, wr_m[0], wr_n[0], wr_d[0]);
    end
    n_checks++;
    if (n_done !== 1 || done_cyc !== 1 || done_wr !== 1'b1) begin
      n_fail++; $display("FAIL one_by_one_done: got count=%0d cyc=%0d wr=%b expected 1 1 1",
                         n_done, done_cyc, done_wr);
    end
  endtask

  task automatic test_abort_and_reset;
    int w;
    int late;
    drive_load(8'd4, 8'd4, 1'b0, 0, 5, 40);
    n_checks++;
    if (n_wr !== 5 || n_done !== 0) begin
      n_fail++; $display("FAIL abort_counts: got wr=%0d done=%0d expected wr=5 done=0", n_wr, n_done);
    end
    n_checks++;
    if ({abort_wr, abort_busy, in_ready} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: got %b expected 000", {abort_wr, abort_busy, in_ready});
    end
    // Second load, killed by reset after its third write
    w = 0; late = 0;
    m_dim = 8'd4; n_dim = 8'd4; start = 1;
    tick;
    start = 0; in_valid = 1;
    for (int i = 0; i < 10 && w < 3; i++) begin
      in_data = 32'h100 + 32'(i);
      tick;
      if (write) w++;
    end
    n_checks++;
    if (w !== 3) begin
      n_fail++; $display("FAIL reset_preload_writes: got %0d expected 3", w);
    end
    #2 reset = 0;
    #1;
    n_checks++;
    if ({in_ready, write, busy, done, err, m_addr, n_addr, data_in} !== 53'h0) begin
      n_fail++; $display("FAIL reset_midload: got %h expected 0",
                         {in_ready, write, busy, done, err, m_addr, n_addr, data_in});
    end
    tick;
    #2 reset = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (write || busy) late++;
    end
    in_valid = 0;
    n_checks++;
    if (late !== 0) begin
      n_fail++; $display("FAIL reset_no_resume: got %0d active cycles expected 0", late);
    end
  endtask

  task automatic test_full_128;
    int bad;
    bad = 0;
    drive_load(8'd128, 8'd128, 1'b0, 0, -1, 17000);
    n_checks++;
    if (n_wr !== 16384) begin
      n_fail++; $display("FAIL full_write_count: got %0d expected 16384", n_wr);
    end
    for (int i = 0; i < 16384; i++) begin
      if ({wr_m[i], wr_n[i], wr_d[i]} !== {8'(i / 128), 8'(i % 128), 32'(i + 1)}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL full_sequence: got %0d bad writes expected 0", bad);
    end
    n_checks++;
    if (wr_m[16383] !== 8'd127 || wr_n[16383] !== 8'd127) begin
      n_fail++; $display("FAIL full_last_addr: got (%0d,%0d) expected (127,127)", wr_m[16383], wr_n[16383]);
    end
    n_checks++;
    if (n_done !== 1 || done_cyc !== 16384 || done_wr !== 1'b1) begin
      n_fail++; $display("FAIL full_done: got count=%0d cyc=%0d wr=%b expected 1 16384 1",
                         n_done, done_cyc, done_wr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_row_major();
    test_back_to_back_transpose();
    test_stall();
    test_illegal_dims();
    test_abort_and_reset();
    test_full_128();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
